// File: rtl/instr_prefetch_queue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : instr_prefetch_queue_if
// Brief    : Memory request/response, redirect and decode handshake bundle
//            for the instruction prefetch queue.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface instr_prefetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // Prefetch queue side
  modport master (
    output imem_req_valid, imem_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : instr_prefetch_queue
// Brief    : Fetch-PC owner and DEPTH-entry {instr,pc} FIFO feeding decode;
//            redirects flush the queue and drop in-flight responses.
//            Optional macro PFQ_BYPASS_EN: empty-queue response bypass.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  instr_prefetch_queue_if.master bus
);
  localparam int             PTR_W      = $clog2(DEPTH);
  localparam int             CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];

  logic [CNT_W:0]   credit;
  logic [31:0]      redir_pc;
  logic             req_valid;
  logic             accept;
  logic             rsp_ok;
  logic             keep;
  logic             head_valid;
  logic             push;
  logic             pop;

  always_comb begin
    credit     = {1'b0, count_q} + {1'b0, outst_q};
    redir_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
    // Occupancy plus in-flight reads never exceeds DEPTH, so a push always fits.
    req_valid  = rst_n && !bus.redirect_valid && (credit < CREDIT_LIM);
    accept     = req_valid && bus.imem_req_ready;
    rsp_ok     = bus.imem_rsp_valid && (outst_q != '0);
    keep       = rsp_ok && (drop_q == '0) && !bus.redirect_valid;
    head_valid = (count_q != '0);
    pop        = head_valid && bus.out_ready && !bus.redirect_valid;
  end

`ifdef PFQ_BYPASS_EN
  logic bypass;

  // A kept word arriving at an empty queue is shown immediately; it is only
  // stored if decode does not take it this cycle.
  assign bypass        = keep && !head_valid;
  assign push          = keep && !(bypass && bus.out_ready);
  assign bus.out_valid = head_valid || bypass;
  assign bus.out_instr = bypass ? bus.imem_rsp_data : instr_mem_q[rd_ptr_q];
  assign bus.out_pc    = bypass ? rsp_pc_q          : pc_mem_q[rd_ptr_q];
`else
  assign push          = keep;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_pc    = pc_mem_q[rd_ptr_q];
`endif

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d    = outst_q + CNT_W'(1);
    end
    if (rsp_ok) begin
      outst_d = outst_d - CNT_W'(1);
    end

    if (bus.redirect_valid) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Every read still in flight after this cycle belongs to the old stream.
      drop_d     = outst_d;
    end else begin
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule
`default_nettype wire
